// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage operand forwarding and load-use stall control
// for the 5-stage pipeline. Forwarding is purely combinational; a small
// RUN/WAIT FSM extends a load-use stall to LOAD_LAT cycles.
// Optional build macro HAZ_STATS_EN adds a saturating stall_cycles counter.

// Per-operand forwarding selector: MEM beats WB, register 0 never forwards.
module hazard_fwd_sel #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);
  // Priority select: newest producer (MEM) first
  always_comb begin
    sel = 2'b00;
    if (mem_we && mem_rd != '0 && mem_rd == src)
      sel = 2'b10;
    else if (wb_we && wb_rd != '0 && wb_rd == src)
      sel = 2'b01;
  end
endmodule

module hazard_forward_unit #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_use_rt,
  input  logic [REG_AW-1:0] EX_rs,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] MEM_rd,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] WB_rd,
  input  logic              WB_RegWrite,
  input  logic              ext_stall,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall,
  output logic              bubble
`ifdef HAZ_STATS_EN
  ,output logic [15:0]      stall_cycles
`endif
);

  localparam int NUM_OPS = 2;
  // WAIT covers stall cycles 2..LOAD_LAT, so it is loaded with LOAD_LAT-2
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt, cnt_nxt;
  logic                             lu_hit;
  logic                             hz_stall;
  logic [NUM_OPS-1:0][REG_AW-1:0]   ex_src;
  logic [NUM_OPS-1:0][1:0]          fwd_sel;

  assign ex_src = {EX_rt, EX_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .src    (ex_src[g]),
      .mem_rd (MEM_rd),
      .mem_we (MEM_RegWrite),
      .wb_rd  (WB_rd),
      .wb_we  (WB_RegWrite),
      .sel    (fwd_sel[g])
    );
  end

  // Forward selects are held at register-file while reset is asserted
  always_comb begin
    ForwardA = rst ? 2'b00 : fwd_sel[0];
    ForwardB = rst ? 2'b00 : fwd_sel[1];
  end

  // Load in EX feeding a source of the instruction in ID
  always_comb begin
    lu_hit = EX_MemRead && EX_rd != '0 &&
             (EX_rd == ID_rs || (ID_use_rt && EX_rd == ID_rt));
  end

  // FSM next state and hazard stall; ext_stall freezes state and counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hz_stall  = 1'b0;
    case (state)
      RUN: begin
        hz_stall = lu_hit;
        if (lu_hit && LOAD_LAT > 1) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        hz_stall = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (ext_stall) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end
  end

  // Outputs: external freeze holds ID/EX rather than bubbling it
  always_comb begin
    stall  = !rst && (ext_stall || hz_stall);
    bubble = !rst && !ext_stall && hz_stall;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZ_STATS_EN
  // Saturating count of hazard stall cycles (bubble marks exactly those)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (bubble && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
